// File: rtl/wts_pkg.sv
// Shared types and constants for the pipe-in write-throughput test sequencer.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
// Contents: FSM state enum, status bit indices, counter widths, saturating increment.
package wts_pkg;

  localparam int CNT_W    = 64;  // clk_counts width
  localparam int WORD_W   = 32;  // words_in / words_checked / transfer_len width
  localparam int STATUS_W = 4;

  // Bit positions inside the status word.
  localparam int STS_ABORTED = 0;
  localparam int STS_BAD_LEN = 1;
  localparam int STS_OVERRUN = 2;
  localparam int STS_TIMEOUT = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ARMED = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } wts_state_t;

  // Word counters stick at all-ones instead of wrapping.
  function automatic logic [WORD_W-1:0] sat_inc_word(input logic [WORD_W-1:0] v);
    return (&v) ? v : v + WORD_W'(1);
  endfunction

endpackage

// File: rtl/wts_cycle_timer.sv
// 64-bit saturating cycle counter with synchronous clear and count enable.
// Latency: count reflects clear/enable one cycle after they are sampled.
// Backpressure: none; enable is sampled every cycle, the count holds at all-ones.
// Ports: okClk, reset (sync, active-high), clear, enable -> count[63:0].
module wts_cycle_timer
  import wts_pkg::*;
(
  input  logic             okClk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge okClk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !(&count)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/write_test_sequencer.sv
// Sequences one pipe-in write-throughput test: clear FIFO/checker, arm, time first write to last check.
// Latency: all outputs registered; state changes and counter updates are visible one cycle after the input.
// Backpressure: none; strobes are only counted, start is ignored while busy, abort beats start.
// Ports: okClk, reset (sync, active-high), start, abort, transfer_len[31:0], pipe_in_write, fifo_valid
//        -> fifo_rst, pattern_rst, timer_on, clk_counts[63:0], words_in[31:0], words_checked[31:0],
//           busy, done, status[3:0] = {timeout, overrun, bad_len, aborted}.
// Build option: define WTC_TIMEOUT_EN to add the DRAIN watchdog (status[3]); otherwise status[3] is 0.
module write_test_sequencer
  import wts_pkg::*;
#(
  parameter int CLEAR_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                okClk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [WORD_W-1:0]   transfer_len,
  input  logic                pipe_in_write,
  input  logic                fifo_valid,
  output logic                fifo_rst,
  output logic                pattern_rst,
  output logic                timer_on,
  output logic [CNT_W-1:0]    clk_counts,
  output logic [WORD_W-1:0]   words_in,
  output logic [WORD_W-1:0]   words_checked,
  output logic                busy,
  output logic                done,
  output logic [STATUS_W-1:0] status
);

  if (CLEAR_CYCLES < 1 || CLEAR_CYCLES > 15) begin : g_bad_clear
    $error("CLEAR_CYCLES must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  wts_state_t        state;
  logic [WORD_W-1:0] len_q;
  logic [3:0]        clear_cnt;
  logic [2:0]        sts_q;      // {overrun, bad_len, aborted}
  logic              timeout_q;

  logic              idle_or_done;
  logic              abort_ok;
  logic              wr_hits_len;
  logic              chk_hits_len;
  logic              timer_en;
  logic              start_ok;
  logic              wd_fire;

  assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
  assign abort_ok     = abort && (state != ST_IDLE);
  assign start_ok     = start && !abort && idle_or_done && (transfer_len != '0);
  assign wr_hits_len  = pipe_in_write && (sat_inc_word(words_in) == len_q);
  assign chk_hits_len = fifo_valid && (sat_inc_word(words_checked) == len_q);

  // The first-strobe cycle in ARMED is part of the measured interval, as is the
  // cycle of the final check; an aborting cycle is not.
  assign timer_en = !abort_ok &&
                    ((state == ST_RUN) || (state == ST_DRAIN) ||
                     ((state == ST_ARMED) && pipe_in_write));

  wts_cycle_timer u_timer (
    .okClk  (okClk),
    .reset  (reset),
    .clear  (start_ok),
    .enable (timer_en),
    .count  (clk_counts)
  );

`ifdef WTC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // Counts consecutive DRAIN cycles with no fifo_valid; fires on the cycle
  // that would bring the count to TIMEOUT_CYCLES.
  always_ff @(posedge okClk) begin
    if (reset || (state != ST_DRAIN) || fifo_valid) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign wd_fire = (state == ST_DRAIN) && !fifo_valid &&
                   (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign status  = {timeout_q, sts_q};
`else
  assign wd_fire = 1'b0;
  assign status  = {1'b0, sts_q};
`endif

  always_ff @(posedge okClk) begin
    if (reset) begin
      state         <= ST_IDLE;
      len_q         <= '0;
      clear_cnt     <= '0;
      sts_q         <= '0;
      timeout_q     <= 1'b0;
      fifo_rst      <= 1'b0;
      pattern_rst   <= 1'b0;
      timer_on      <= 1'b0;
      words_in      <= '0;
      words_checked <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else if (abort_ok) begin
      // Counters freeze where they are so the partial result stays readable.
      state              <= ST_IDLE;
      fifo_rst           <= 1'b0;
      pattern_rst        <= 1'b0;
      timer_on           <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      sts_q[STS_ABORTED] <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start && !abort) begin
            if (transfer_len != '0) begin
              state         <= ST_CLEAR;
              len_q         <= transfer_len;
              clear_cnt     <= 4'(CLEAR_CYCLES - 1);
              sts_q         <= '0;
              timeout_q     <= 1'b0;
              fifo_rst      <= 1'b1;
              pattern_rst   <= 1'b1;
              words_in      <= '0;
              words_checked <= '0;
              busy          <= 1'b1;
              done          <= 1'b0;
            end else begin
              sts_q[STS_BAD_LEN] <= 1'b1;
            end
          end else if ((state == ST_DONE) && pipe_in_write) begin
            sts_q[STS_OVERRUN] <= 1'b1;
          end
        end

        ST_CLEAR: begin
          if (clear_cnt == 4'd0) begin
            state       <= ST_ARMED;
            fifo_rst    <= 1'b0;
            pattern_rst <= 1'b0;
          end else begin
            clear_cnt <= clear_cnt - 4'd1;
          end
        end

        ST_ARMED: begin
          if (fifo_valid) begin
            words_checked <= sat_inc_word(words_checked);
          end
          if (pipe_in_write) begin
            words_in <= WORD_W'(1);
            timer_on <= 1'b1;
            state    <= wr_hits_len ? ST_DRAIN : ST_RUN;
          end
        end

        ST_RUN: begin
          if (pipe_in_write) begin
            words_in <= sat_inc_word(words_in);
          end
          if (fifo_valid) begin
            words_checked <= sat_inc_word(words_checked);
          end
          if (chk_hits_len) begin
            state    <= ST_DONE;
            timer_on <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else if (wr_hits_len) begin
            state <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (pipe_in_write) begin
            sts_q[STS_OVERRUN] <= 1'b1;
          end
          if (fifo_valid) begin
            words_checked <= sat_inc_word(words_checked);
          end
          if (chk_hits_len || wd_fire) begin
            state    <= ST_DONE;
            timer_on <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
`ifdef WTC_TIMEOUT_EN
            if (!chk_hits_len) begin
              timeout_q <= 1'b1;
            end
`endif
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_write_test_sequencer.sv
// Self-checking bench for write_test_sequencer: directed scenarios with a result scoreboard.
// Latency: inputs driven 1 time unit after posedge, outputs sampled at the same point.
// Backpressure: n/a.
module tb_write_test_sequencer;

  logic        okClk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] transfer_len;
  logic        pipe_in_write;
  logic        fifo_valid;
  logic        fifo_rst;
  logic        pattern_rst;
  logic        timer_on;
  logic [63:0] clk_counts;
  logic [31:0] words_in;
  logic [31:0] words_checked;
  logic        busy;
  logic        done;
  logic [3:0]  status;

  always #5 okClk = ~okClk;

  write_test_sequencer #(
    .CLEAR_CYCLES   (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .okClk         (okClk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .transfer_len  (transfer_len),
    .pipe_in_write (pipe_in_write),
    .fifo_valid    (fifo_valid),
    .fifo_rst      (fifo_rst),
    .pattern_rst   (pattern_rst),
    .timer_on      (timer_on),
    .clk_counts    (clk_counts),
    .words_in      (words_in),
    .words_checked (words_checked),
    .busy          (busy),
    .done          (done),
    .status        (status)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] wi;
    logic [31:0] wc;
    logic [63:0] clk;
    logic        dn;
    logic        bz;
    logic        tm;
    logic [3:0]  st;
  } res_t;

  res_t sb_q[$];

  task automatic tick();
    @(posedge okClk);
    #1;
  endtask

  task automatic expect_result(input string name, input logic [31:0] wi, input logic [31:0] wc,
                               input logic [63:0] clk, input logic dn, input logic bz,
                               input logic tm, input logic [3:0] st);
    res_t r;
    r.name = name; r.wi = wi; r.wc = wc; r.clk = clk;
    r.dn = dn; r.bz = bz; r.tm = tm; r.st = st;
    sb_q.push_back(r);
  endtask

  task automatic score();
    res_t r;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 64'd1, 64'd0);
      return;
    end
    r = sb_q.pop_front();
    check({r.name, ".words_in"},      words_in,      r.wi);
    check({r.name, ".words_checked"}, words_checked, r.wc);
    check({r.name, ".clk_counts"},    clk_counts,    r.clk);
    check({r.name, ".done"},          done,          r.dn);
    check({r.name, ".busy"},          busy,          r.bz);
    check({r.name, ".timer_on"},      timer_on,      r.tm);
    check({r.name, ".status"},        status,        r.st);
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".fifo_rst"},      fifo_rst,      0);
    check({name, ".pattern_rst"},   pattern_rst,   0);
    check({name, ".timer_on"},      timer_on,      0);
    check({name, ".clk_counts"},    clk_counts,    0);
    check({name, ".words_in"},      words_in,      0);
    check({name, ".words_checked"}, words_checked, 0);
    check({name, ".busy"},          busy,          0);
    check({name, ".done"},          done,          0);
    check({name, ".status"},        status,        0);
  endtask

  task automatic do_start(input logic [31:0] len);
    transfer_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts the cycles fifo_rst stays high; optionally strobes once inside CLEAR.
  task automatic count_clear(input string name, input bit strobe_inside);
    int n = 0;
    while (fifo_rst && n < 32) begin
      if (n == 0) check({name, ".pattern_rst"}, pattern_rst, 1);
      pipe_in_write = strobe_inside && (n == 0);
      n++;
      tick();
    end
    pipe_in_write = 1'b0;
    check({name, ".clear_len"}, n, 4);
    check({name, ".clear_cnt"}, words_in, 0);
  endtask

  // Strobe n_wr words on consecutive cycles; n_vl valids start lag cycles after the first strobe.
  task automatic stream(input int n_wr, input int n_vl, input int lag);
    int last = (n_wr > lag + n_vl) ? n_wr : lag + n_vl;
    for (int c = 0; c < last; c++) begin
      pipe_in_write = (c < n_wr);
      fifo_valid    = (c >= lag) && (c < lag + n_vl);
      tick();
    end
    pipe_in_write = 1'b0;
    fifo_valid    = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check({name, ".done_seen"}, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; transfer_len = '0;
    pipe_in_write = 1'b0; fifo_valid = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Zero length: only bad_len changes, no clear pulse.
    do_start(32'd0);
    check("badlen.status", status, 4'b0010);
    check("badlen.busy", busy, 0);
    check("badlen.done", done, 0);
    for (int i = 0; i < 3; i++) begin
      check("badlen.fifo_rst", fifo_rst, 0);
      tick();
    end

    // Length 8, valids lag strobes by 2.
    expect_result("len8", 8, 8, 10, 1, 0, 0, 4'b0000);
    do_start(32'd8);
    count_clear("len8", 1'b0);
    stream(8, 8, 2);
    wait_done("len8", 20);
    score();

    // Length 4 with a strobe in CLEAR and two extra strobes.
    expect_result("len4", 4, 4, 6, 1, 0, 0, 4'b0100);
    do_start(32'd4);
    count_clear("len4", 1'b1);
    stream(6, 6, 2);
    wait_done("len4", 20);
    score();

    // Abort together with start mid-run.
    expect_result("abort", 5, 0, 5, 0, 0, 0, 4'b0001);
    do_start(32'd16);
    count_clear("abort", 1'b0);
    stream(5, 0, 0);
    transfer_len = 32'd16;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    score();
    tick();
    check("abort.fifo_rst", fifo_rst, 0);
    check("abort.status_held", status, 4'b0001);

    do_start(32'd2);
    check("restart.status", status, 4'b0000);
    check("restart.busy", busy, 1);
    expect_result("restart", 2, 2, 3, 1, 0, 0, 4'b0000);
    count_clear("restart", 1'b0);
    stream(2, 2, 1);
    wait_done("restart", 20);
    score();

    // Reset in RUN with a strobe on the same cycle.
    do_start(32'd8);
    count_clear("midreset", 1'b0);
    stream(3, 0, 0);
    check("midreset.timer_on", timer_on, 1);
    check("midreset.busy", busy, 1);
    pipe_in_write = 1'b1;
    reset = 1'b1;
    tick();
    pipe_in_write = 1'b0;
    reset = 1'b0;
    check_all_zero("midreset");
    expect_result("post_reset", 3, 3, 4, 1, 0, 0, 4'b0000);
    do_start(32'd3);
    count_clear("post_reset", 1'b0);
    stream(3, 3, 1);
    wait_done("post_reset", 20);
    score();

    // Drain stall: one word never checked.
    do_start(32'd4);
    count_clear("stall", 1'b0);
`ifdef WTC_TIMEOUT_EN
    expect_result("timeout", 4, 3, 20, 1, 0, 0, 4'b1000);
    stream(4, 3, 1);
    repeat (15) tick();
    check("timeout.early", done, 0);
    tick();
    score();
`else
    expect_result("no_timeout", 4, 3, 44, 0, 1, 1, 4'b0000);
    stream(4, 3, 1);
    repeat (40) tick();
    score();
    check("no_timeout.status3", status[3], 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("stall_abort.busy", busy, 0);
    check("stall_abort.status", status, 4'b0001);
`endif

    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
